// File: rtl/nybble_fetch_if.sv
// Memory, opcode and redirect signals shared between the fetch stage
// (master) and its environment: byte memory plus execute core (slave).
interface nybble_fetch_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_rdata;
  logic                  op_valid;
  logic                  op_ready;
  logic [3:0]            op;
  logic [15:0]           op_pc;
  logic [15:0]           op_operand;
  logic [15:0]           op_target;
  logic [15:0]           op_next_pc;
  logic                  redirect;
  logic [15:0]           redirect_pc;

  modport master (
    output mem_req, mem_addr, op_valid, op, op_pc, op_operand, op_target, op_next_pc,
    input  mem_ack, mem_rdata, op_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, op_valid, op, op_pc, op_operand, op_target, op_next_pc,
    output mem_ack, mem_rdata, op_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/nybble_fetch.sv
// nybbleForth fetch/predecode: reads instruction bytes, splits them into
// two opcodes (high nibble first), gathers inline operands and presents one
// decoded opcode per handshake. Control transfers arrive via redirect.
module nybble_fetch #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input logic            clock,
  input logic            reset_n,
  nybble_fetch_if.master bus
);

  typedef enum logic [2:0] {FETCH, WAIT_I, OPND_LO, OPND_HI, PRESENT} state_t;

  state_t                state, state_nxt;
  logic [15:0]           pc, pc_nxt;
  logic [15:0]           ipc, ipc_nxt;          // address of the byte held in ir
  logic [7:0]            ir, ir_nxt;
  logic                  nib_lo, nib_lo_nxt;    // 0: high nibble current, 1: low
  logic                  discard, discard_nxt;  // drop the byte of the request in flight
  logic                  mem_req, mem_req_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr, mem_addr_nxt;
  logic                  op_valid, op_valid_nxt;
  logic [3:0]            op, op_nxt;
  logic [15:0]           op_pc, op_pc_nxt;
  logic [15:0]           op_operand, op_operand_nxt;
  logic [15:0]           op_target, op_target_nxt;
  logic [15:0]           op_next_pc, op_next_pc_nxt;

  logic                  eval;
  logic [3:0]            eval_nib;
  logic [15:0]           eval_pc;
  logic                  mem_done;
  logic [15:0]           pc_inc;
  logic signed [15:0]    branch_off;

  // call, 0branch and literal carry inline operand bytes
  function automatic logic has_operand(input logic [3:0] n);
    return (n == 4'd1) || (n == 4'd3) || (n == 4'd6);
  endfunction

  assign mem_done   = mem_req && bus.mem_ack;
  assign pc_inc     = pc + 16'd1;
  assign branch_off = {{8{bus.mem_rdata[7]}}, bus.mem_rdata};

  // Next-state logic: fetch sequencing, operand gathering, handshake, redirect
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    ipc_nxt        = ipc;
    ir_nxt         = ir;
    nib_lo_nxt     = nib_lo;
    discard_nxt    = discard;
    mem_req_nxt    = mem_req;
    mem_addr_nxt   = mem_addr;
    op_valid_nxt   = op_valid;
    op_nxt         = op;
    op_pc_nxt      = op_pc;
    op_operand_nxt = op_operand;
    op_target_nxt  = op_target;
    op_next_pc_nxt = op_next_pc;
    eval           = 1'b0;
    eval_nib       = 4'h0;
    eval_pc        = pc;

    case (state)
      FETCH: begin
        if (discard) begin
          // stale request from before a redirect: wait out its ack, drop the byte
          if (mem_done) begin
            mem_req_nxt = 1'b0;
            discard_nxt = 1'b0;
          end
        end else begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = pc[ADDR_WIDTH-1:0];
          state_nxt    = WAIT_I;
        end
      end
      WAIT_I: begin
        if (mem_done) begin
          ir_nxt      = bus.mem_rdata;
          ipc_nxt     = pc;
          pc_nxt      = pc_inc;
          nib_lo_nxt  = 1'b0;
          mem_req_nxt = 1'b0;
          eval        = 1'b1;
          eval_nib    = bus.mem_rdata[7:4];
          eval_pc     = pc_inc;
        end
      end
      OPND_LO: begin
        if (!mem_req) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = pc[ADDR_WIDTH-1:0];
        end else if (mem_done) begin
          mem_req_nxt = 1'b0;
          pc_nxt      = pc_inc;
          if (op == 4'd3) begin
            // branch offset is relative to the byte after the offset
            op_operand_nxt = branch_off;
            op_target_nxt  = pc_inc + branch_off;
            op_next_pc_nxt = pc_inc;
            op_valid_nxt   = 1'b1;
            state_nxt      = PRESENT;
          end else begin
            op_operand_nxt = {8'h00, bus.mem_rdata};
            state_nxt      = OPND_HI;
          end
        end
      end
      OPND_HI: begin
        if (!mem_req) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = pc[ADDR_WIDTH-1:0];
        end else if (mem_done) begin
          mem_req_nxt    = 1'b0;
          pc_nxt         = pc_inc;
          op_operand_nxt = {bus.mem_rdata, op_operand[7:0]};
          op_next_pc_nxt = pc_inc;
          op_valid_nxt   = 1'b1;
          state_nxt      = PRESENT;
        end
      end
      PRESENT: begin
        if (op_valid && bus.op_ready) begin
          op_valid_nxt = 1'b0;
          if (!nib_lo) begin
            // low nibble's operands follow the high nibble's, so start at pc
            nib_lo_nxt = 1'b1;
            eval       = 1'b1;
            eval_nib   = ir[3:0];
            eval_pc    = pc;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = FETCH;
    endcase

    if (eval) begin
      op_nxt         = eval_nib;
      op_pc_nxt      = ipc_nxt;
      op_operand_nxt = 16'h0000;
      op_target_nxt  = 16'h0000;
      op_next_pc_nxt = eval_pc;
      if (has_operand(eval_nib)) begin
        op_valid_nxt = 1'b0;
        state_nxt    = OPND_LO;
      end else begin
        op_valid_nxt = 1'b1;
        state_nxt    = PRESENT;
      end
    end

    // redirect wins over everything; an in-flight request is kept until acked
    if (bus.redirect) begin
      state_nxt    = FETCH;
      pc_nxt       = bus.redirect_pc;
      nib_lo_nxt   = 1'b0;
      op_valid_nxt = 1'b0;
      mem_req_nxt  = mem_req && !bus.mem_ack;
      discard_nxt  = mem_req && !bus.mem_ack;
      mem_addr_nxt = mem_addr;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      ipc        <= 16'h0000;
      ir         <= 8'h00;
      nib_lo     <= 1'b0;
      discard    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      op_valid   <= 1'b0;
      op         <= 4'h0;
      op_pc      <= 16'h0000;
      op_operand <= 16'h0000;
      op_target  <= 16'h0000;
      op_next_pc <= 16'h0000;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ipc        <= ipc_nxt;
      ir         <= ir_nxt;
      nib_lo     <= nib_lo_nxt;
      discard    <= discard_nxt;
      mem_req    <= mem_req_nxt;
      mem_addr   <= mem_addr_nxt;
      op_valid   <= op_valid_nxt;
      op         <= op_nxt;
      op_pc      <= op_pc_nxt;
      op_operand <= op_operand_nxt;
      op_target  <= op_target_nxt;
      op_next_pc <= op_next_pc_nxt;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = mem_addr;
  assign bus.op_valid   = op_valid;
  assign bus.op         = op;
  assign bus.op_pc      = op_pc;
  assign bus.op_operand = op_operand;
  assign bus.op_target  = op_target;
  assign bus.op_next_pc = op_next_pc;

endmodule

// File: tb/tb_nybble_fetch.sv
// Directed bench for nybble_fetch: byte memory model with adjustable ack
// latency, hand-computed expectations checked with immediate assertions.
module tb_nybble_fetch;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  nybble_fetch_if #(.ADDR_WIDTH(12)) bus();

  nybble_fetch #(.ADDR_WIDTH(12), .RESET_PC(16'h0000)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:4095];
  int lat    = 1;
  int cnt    = 0;
  int tests  = 0;
  int fails  = 0;
  int hs_cnt = 0;

  // Memory model: ack a held request after 'lat' extra cycles
  always @(negedge clock) begin
    bus.mem_ack = 1'b0;
    if (!reset_n) begin
      cnt = 0;
    end else if (bus.mem_req) begin
      if (cnt >= lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Count accepted opcodes
  always @(posedge clock) begin
    if (reset_n && bus.op_valid && bus.op_ready) hs_cnt <= hs_cnt + 1;
  end

  // Hard time limit
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.op_valid && n < 100) begin tick(); n++; end
    chk({tag, " op_valid"}, {15'd0, bus.op_valid}, 16'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [11:0] a);
    int n = 0;
    while (!(bus.mem_req && bus.mem_addr == a) && n < 100) begin tick(); n++; end
    chk({tag, " req addr"}, {4'h0, bus.mem_addr}, {4'h0, a});
  endtask

  task automatic take(input string tag, input logic [3:0] e_op, input logic [15:0] e_pc,
                      input logic [15:0] e_opnd, input logic [15:0] e_tgt, input logic [15:0] e_next);
    wait_valid(tag);
    chk({tag, " op"},      {12'd0, bus.op}, {12'd0, e_op});
    chk({tag, " op_pc"},   bus.op_pc,      e_pc);
    chk({tag, " operand"}, bus.op_operand, e_opnd);
    chk({tag, " target"},  bus.op_target,  e_tgt);
    chk({tag, " next_pc"}, bus.op_next_pc, e_next);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
  endtask

  task automatic do_redirect(input logic [15:0] p);
    bus.redirect    = 1'b1;
    bus.redirect_pc = p;
    tick();
    bus.redirect    = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mem_req"},    {15'd0, bus.mem_req},  16'd0);
    chk({tag, " mem_addr"},   {4'h0, bus.mem_addr},  16'd0);
    chk({tag, " op_valid"},   {15'd0, bus.op_valid}, 16'd0);
    chk({tag, " op"},         {12'd0, bus.op},       16'd0);
    chk({tag, " op_pc"},      bus.op_pc,             16'd0);
    chk({tag, " op_operand"}, bus.op_operand,        16'd0);
    chk({tag, " op_target"},  bus.op_target,         16'd0);
    chk({tag, " op_next_pc"}, bus.op_next_pc,        16'd0);
  endtask

  initial begin
    int hs_before;
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    bus.op_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;

    // literal 0x1234 followed by add
    mem[12'h000] = 8'h67; mem[12'h001] = 8'h34; mem[12'h002] = 8'h12;
    // 0branch back to its own byte
    mem[12'h010] = 8'h30; mem[12'h011] = 8'hFE;
    // literal 0x5678 followed by op 5, used under backpressure
    mem[12'h012] = 8'h65; mem[12'h013] = 8'h78; mem[12'h014] = 8'h56;
    // redirect target: op 7 then undefined op 11
    mem[12'h200] = 8'h7B;

    repeat (3) tick();
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // literal plus add
    take("lit", 4'd6, 16'h0000, 16'h1234, 16'h0000, 16'h0003);
    take("add", 4'd7, 16'h0000, 16'h0000, 16'h0000, 16'h0003);
    n = 0;
    while (!bus.mem_req && n < 100) begin tick(); n++; end
    chk("next fetch addr", {4'h0, bus.mem_addr}, 16'h0003);
    n = 0;
    while (!bus.op_valid && n < 10) begin tick(); n++; end
    chk("req to valid cycles", n[15:0], 16'd2);
    take("nop hi", 4'd0, 16'h0003, 16'h0000, 16'h0000, 16'h0004);
    take("nop lo", 4'd0, 16'h0003, 16'h0000, 16'h0000, 16'h0004);

    // 0branch with negative offset
    do_redirect(16'h0010);
    take("0br", 4'd3, 16'h0010, 16'hFFFE, 16'h0010, 16'h0012);
    take("0br lo", 4'd0, 16'h0010, 16'h0000, 16'h0000, 16'h0012);

    // backpressure on a literal
    wait_valid("bp");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp op_valid", {15'd0, bus.op_valid}, 16'd1);
      chk("bp mem_req",  {15'd0, bus.mem_req},  16'd0);
      chk("bp op",       {12'd0, bus.op},       16'd6);
      chk("bp operand",  bus.op_operand,        16'h5678);
      chk("bp target",   bus.op_target,         16'h0000);
      chk("bp next_pc",  bus.op_next_pc,        16'h0015);
    end
    hs_before    = hs_cnt;
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    chk("bp delivered once", 16'(hs_cnt - hs_before), 16'd1);
    take("bp lo", 4'd5, 16'h0012, 16'h0000, 16'h0000, 16'h0015);

    // redirect while a call operand read is outstanding
    lat = 3;
    mem[12'h000] = 8'h10;
    do_redirect(16'h0000);
    wait_addr("call opnd", 12'h001);
    do_redirect(16'h0200);
    chk("rd op_valid",    {15'd0, bus.op_valid}, 16'd0);
    chk("rd held req",    {15'd0, bus.mem_req},  16'd1);
    chk("rd held addr",   {4'h0, bus.mem_addr},  16'h0001);
    wait_addr("rd new", 12'h200);
    lat = 1;
    take("rd op7",  4'd7,  16'h0200, 16'h0000, 16'h0000, 16'h0201);
    take("rd op11", 4'd11, 16'h0200, 16'h0000, 16'h0000, 16'h0201);

    // reset while waiting for an instruction byte
    lat = 5;
    n = 0;
    while (!bus.mem_req && n < 100) begin tick(); n++; end
    chk("pre-reset req", {15'd0, bus.mem_req}, 16'd1);
    reset_n = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    reset_n = 1'b1;
    lat = 1;
    n = 0;
    while (!bus.mem_req && n < 100) begin tick(); n++; end
    chk("post-reset addr", {4'h0, bus.mem_addr}, 16'h0000);
    take("call", 4'd1, 16'h0000, 16'h1234, 16'h0000, 16'h0003);
    take("call lo", 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0003);

    // pc wrap-around
    mem[12'hFFF] = 8'h60; mem[12'h000] = 8'hCD; mem[12'h001] = 8'hAB;
    do_redirect(16'hFFFF);
    take("wrap lit", 4'd6, 16'hFFFF, 16'hABCD, 16'h0000, 16'h0002);
    take("wrap lo",  4'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0002);
    wait_addr("wrap next", 12'h002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nybble_fetch.md
Name: nybble_fetch

Overview:
- Instruction fetch and predecode stage that sits directly upstream of the nybbleForth execute core.
- Reads instruction bytes from byte-wide main memory and splits each byte into two 4-bit opcodes, high nibble first.
- Gathers each opcode's inline operand bytes and presents one decoded opcode per handshake.
- Never alters control flow itself; call, exit and taken 0branch are applied by the consumer through a redirect.

Parameters:
- ADDR_WIDTH, 12, memory byte address width; mem_addr = pc[ADDR_WIDTH-1:0].
- RESET_PC, 16'h0000, program pointer loaded at reset.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  read request; held with mem_addr stable until mem_ack.
- mem_addr  out  ADDR_WIDTH  byte address of the request.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in that cycle.
- mem_rdata  in  8  read data.
- op_valid  out  1  decoded opcode available.
- op_ready  in  1  consumer accepts the opcode when op_valid && op_ready.
- op  out  4  opcode nibble.
- op_pc  out  16  address of the instruction byte holding op.
- op_operand  out  16  inline operand; 0 when the opcode has none.
- op_target  out  16  0branch destination; 0 for other opcodes.
- op_next_pc  out  16  pc following this opcode's operand bytes.
- redirect  in  1  one-cycle control-transfer pulse.
- redirect_pc  in  16  new program pointer.

Behaviour:
- Reset (async assert):
  - pc=RESET_PC, state=FETCH.
  - mem_req=0, mem_addr=0, op_valid=0.
  - op, op_pc, op_operand, op_target, op_next_pc all 0.
  - nibble index=HI, discard=0.
- States: FETCH -> WAIT_I -> (OPND_LO -> [OPND_HI]) -> PRESENT.
- FETCH: assert mem_req with mem_addr=pc. Request issues in the first cycle after reset release.
- WAIT_I: on mem_ack, latch the byte into the instruction register, pc+=1, nibble=HI, then evaluate the current nibble.
- Operand fetch per current nibble, read sequentially from pc:
  - op 1 (call) and op 6 (literal): two bytes, operand={byte1,byte0} (little-endian), pc+=2.
  - op 3 (0branch): one byte, operand=sign-extended byte, pc+=1, op_target = pc_after_offset + operand, mod 2^16.
  - All other ops, including 0, 2, 4, 5, 7-10 and the undefined ops 11-15: no fetch, go straight to PRESENT. Undefined ops are passed through unmodified; halting is the consumer's decision.
- PRESENT: op_valid=1; all op_* outputs are held stable until the handshake.
- On handshake:
  - If nibble=HI: set nibble=LO, evaluate the low nibble. Its operands are read from the current pc, i.e. after the high nibble's operands.
  - If nibble=LO: go to FETCH at pc.
- Throughput: with single-cycle memory ack, a no-operand byte yields op_valid 2 cycles after mem_req. Maximum one opcode per cycle once presented.
- Memory handshake:
  - Single outstanding request.
  - mem_req deasserts in the cycle after mem_ack.
  - mem_req is never withdrawn before its ack.
- Redirect:
  - Priority over every other event, including a same-cycle handshake. The handshake still counts as consumed.
  - Next cycle: op_valid=0, pc=redirect_pc, nibble=HI, state=FETCH.
  - If a request is outstanding, set discard=1. Keep mem_req and mem_addr until its ack, drop that byte, then issue the request at redirect_pc.
  - Redirect while discard=1: update the pending pc only; one discard only.
- pc arithmetic is 16-bit and wraps at 0xFFFF->0x0000. The address is truncated to ADDR_WIDTH.
- A reset asserted mid-operation abandons everything immediately. A late mem_ack arriving after reset release, with no request issued, is ignored.

Test Plan:
- Literal plus add:
  - Stimulus: mem[0]=0x67, mem[1]=0x34, mem[2]=0x12, op_ready=1.
  - Required: op=6, operand=0x1234, op_pc=0, next_pc=3; then op=7, operand=0, next_pc=3; then mem_addr=3.
- 0branch:
  - Stimulus: pc=0x10, mem[0x10]=0x30, mem[0x11]=0xFE.
  - Required: op=3, operand=0xFFFE, target=0x0010, next_pc=0x12; then op=0, next_pc=0x12.
- Backpressure:
  - Stimulus: op_ready=0 for 5 cycles while op_valid.
  - Required: op, op_operand, op_target and op_next_pc stable; no new mem_req; first op delivered exactly once after ready rises.
- Redirect during operand wait:
  - Stimulus: call byte 0x10 at 0; mem_ack delayed 3 cycles; redirect to 0x0200 during the wait.
  - Required: the stale byte is discarded and the next mem_addr is 0x200.
- Reset mid-fetch:
  - Stimulus: reset_n low for 1 cycle while in WAIT_I.
  - Required: outputs return to reset values; first post-reset mem_addr=RESET_PC.
- Wrap-around:
  - Stimulus: pc=0xFFFF, mem[0xFFF]=0x60, mem[0]=0xCD, mem[1]=0xAB.
  - Required: operand=0xABCD, next_pc=0x0002.
